fetch_ctrl: RTL and testbench

Multi-cycle instruction-fetch controller sitting between the program counter register and the synchronous instruction ROM. It sequences each fetch (issue ROM read, capture instruction word, advance or redirect the PC) in free-run or single-step mode. It presents the fetched word and a one-cycle valid strobe to the downstream datapath and board display logic, and supports stall, branch redirect and halt.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/pc_next.sv | 17 +
 rtl/fetch_ctrl.sv | 100 ++++++++++
 tb/tb_fetch_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-controller types and constants: state encoding, PC increment, halt opcode.
// Pure declarations; no logic, no latency, no flow control.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam logic [31:0] HALT_CODE_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/pc_next.sv
// Next-PC select: sequential increment (mod 2^32) or word-aligned branch target.
// Purely combinational, zero latency, no flow control.
module pc_next
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        branch_i,
    input  logic [31:0] target_i,
    output logic [31:0] next_o
);

    logic [31:0] target_aligned;

    assign target_aligned = target_i & ~32'h3;
    assign next_o         = branch_i ? target_aligned : pc_i + PC_STEP;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: FETCH/WAIT/EXEC per word, 3-cycle minimum period.
// stall holds EXEC indefinitely; a HALT_CODE word parks the controller until reset.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W    = 6,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_CODE = HALT_CODE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic              stall,
    input  logic              branch_valid,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       rom_data,
    output logic              rom_rd_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [31:0]       pc,
    output logic [31:0]       ir,
    output logic              ir_valid,
    output logic              halted,
    output logic [15:0]       fetch_cnt
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, pc_nxt;
    logic [31:0] ir_q, ir_d;
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic        rd_en_q, rd_en_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        is_halt_word;
    logic        retire;

    assign is_halt_word = (rom_data == HALT_CODE);
    assign retire       = (state_q == ST_EXEC) && !stall;

    pc_next u_pc_next (
        .pc_i     (pc_q),
        .branch_i (branch_valid),
        .target_i (branch_target),
        .next_o   (pc_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (run || step) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT:  state_d = is_halt_word ? ST_HALT : ST_EXEC;
            ST_EXEC:  if (!stall) state_d = run ? ST_FETCH : ST_IDLE;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed one cycle early so every strobe leaves a flop.
    always_comb begin
        rd_en_d     = (state_d == ST_FETCH);
        valid_d     = (state_q == ST_WAIT) && !is_halt_word;
        halted_d    = halted_q || ((state_q == ST_WAIT) && is_halt_word);
        ir_d        = (state_q == ST_WAIT) ? rom_data : ir_q;
        pc_d        = retire ? pc_nxt : pc_q;
        fetch_cnt_d = retire ? fetch_cnt_q + 16'd1 : fetch_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            ir_q        <= 32'h0;
            fetch_cnt_q <= 16'h0;
            rd_en_q     <= 1'b0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            fetch_cnt_q <= fetch_cnt_d;
            rd_en_q     <= rd_en_d;
            valid_q     <= valid_d;
            halted_q    <= halted_d;
        end
    end

    assign rom_rd_en = rd_en_q;
    assign rom_addr  = pc_q[ADDR_W+1:2];
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign ir_valid  = valid_q;
    assign halted    = halted_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a fetch-level reference model and synchronous ROM.
module tb_fetch_ctrl;

    localparam int          ADDR_W = 6;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              run = 1'b0;
    logic              step = 1'b0;
    logic              stall = 1'b0;
    logic              branch_valid = 1'b0;
    logic [31:0]       branch_target = 32'h0;
    logic [31:0]       rom_data = 32'h0;
    logic              rom_rd_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       pc;
    logic [31:0]       ir;
    logic              ir_valid;
    logic              halted;
    logic [15:0]       fetch_cnt;

    logic [31:0] rom [DEPTH];
    logic        preload = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;
    int rd_pulses = 0;
    int v_pulses  = 0;

    // Reference model: m_age counts cycles into the current fetch (-1 = not fetching).
    int          m_age  = -1;
    logic        m_halt = 1'b0;
    logic [31:0] m_pc   = 32'h0;
    logic [31:0] m_ir   = 32'h0;
    logic [15:0] m_cnt  = 16'h0;

    fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(32'h0), .HALT_CODE(HALT)) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .step          (step),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .rom_data      (rom_data),
        .rom_rd_en     (rom_rd_en),
        .rom_addr      (rom_addr),
        .pc            (pc),
        .ir            (ir),
        .ir_valid      (ir_valid),
        .halted        (halted),
        .fetch_cnt     (fetch_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_rd_en) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_age = -1; m_halt = 1'b0; m_pc = 32'h0; m_ir = 32'h0; m_cnt = 16'h0;
        end else if (!m_halt) begin
            if (preload) m_cnt = 16'hFFFF;
            if (m_age < 0) begin
                if (run || step) m_age = 0;
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (m_age == 1) begin
                m_ir = rom[m_pc[ADDR_W+1:2]];
                if (m_ir == HALT) begin
                    m_halt = 1'b1;
                    m_age  = -1;
                end else begin
                    m_age = 2;
                end
            end else if (stall) begin
                m_age = m_age + 1;
            end else begin
                m_pc  = branch_valid ? (branch_target & ~32'h3) : m_pc + 32'd4;
                m_cnt = m_cnt + 16'd1;
                m_age = run ? 0 : -1;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_rd_en",  32'(rom_rd_en), 32'(m_age == 0));
        chk("m_valid",  32'(ir_valid),  32'(m_age == 2));
        chk("m_addr",   32'(rom_addr),  32'(m_pc[ADDR_W+1:2]));
        chk("m_pc",     pc,             m_pc);
        chk("m_ir",     ir,             m_ir);
        chk("m_halted", 32'(halted),    32'(m_halt));
        chk("m_cnt",    32'(fetch_cnt), 32'(m_cnt));
        if (rom_rd_en) rd_pulses++;
        if (ir_valid)  v_pulses++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        #1 rst = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},    pc,             32'h0);
        chk({tag, "_ir"},    ir,             32'h0);
        chk({tag, "_valid"}, 32'(ir_valid),  32'h0);
        chk({tag, "_rd"},    32'(rom_rd_en), 32'h0);
        chk({tag, "_addr"},  32'(rom_addr),  32'h0);
        chk({tag, "_halt"},  32'(halted),    32'h0);
        chk({tag, "_cnt"},   32'(fetch_cnt), 32'h0);
    endtask

    initial begin
        int b_rd, b_v;
        for (int i = 0; i < DEPTH; i++) rom[i] = 32'h1000_0000 + 32'(i);

        #1 rst = 1'b0;
        #2 chk_reset_vals("rst0");
        tick(2);
        #1 rst = 1'b1;
        tick(1);

        // Free run: three fetches back to back
        b_rd = rd_pulses; b_v = v_pulses;
        run = 1'b1;
        tick(9);
        chk("run_ir2",    ir,            32'h1000_0002);
        chk("run_valid",  32'(ir_valid), 32'h1);
        chk("run_pc8",    pc,            32'h8);
        run = 1'b0;
        tick(1);
        chk("run_pc12",   pc,             32'hC);
        chk("run_cnt3",   32'(fetch_cnt), 32'h3);
        chk("run_nvalid", 32'(v_pulses - b_v),  32'h3);
        chk("run_nrd",    32'(rd_pulses - b_rd), 32'h3);

        // Single step, second step while busy is ignored
        do_reset();
        b_rd = rd_pulses; b_v = v_pulses;
        step = 1'b1; tick(1); step = 1'b0;
        chk("step_rd", 32'(rom_rd_en), 32'h1);
        tick(1); step = 1'b1; tick(1); step = 1'b0;
        chk("step_valid", 32'(ir_valid), 32'h1);
        tick(1);
        chk("step_pc4",  pc,             32'h4);
        chk("step_cnt1", 32'(fetch_cnt), 32'h1);
        tick(4);
        chk("step_nrd",    32'(rd_pulses - b_rd), 32'h1);
        chk("step_nvalid", 32'(v_pulses - b_v),   32'h1);
        chk("step_pchold", pc,                    32'h4);

        // Stall with a pending branch: stall wins, branch taken when it drops
        step = 1'b1; tick(1); step = 1'b0;
        tick(1);
        stall = 1'b1; branch_valid = 1'b1; branch_target = 32'h23;
        tick(6);
        chk("stall_pchold", pc, 32'h4);
        stall = 1'b0;
        tick(1);
        chk("br_pc", pc, 32'h20);
        branch_valid = 1'b0;
        step = 1'b1; tick(1); step = 1'b0;
        chk("br_addr", 32'(rom_addr),  32'h8);
        chk("br_rd",   32'(rom_rd_en), 32'h1);
        tick(3);

        // Halt opcode at word 3
        do_reset();
        rom[3] = HALT;
        run = 1'b1;
        tick(13);
        chk("halt_flag", 32'(halted),    32'h1);
        chk("halt_pc",   pc,             32'hC);
        chk("halt_cnt",  32'(fetch_cnt), 32'h3);
        chk("halt_ir",   ir,             HALT);
        b_rd = rd_pulses;
        tick(15);
        chk("halt_nrd", 32'(rd_pulses - b_rd), 32'h0);
        run = 1'b0;
        rom[3] = 32'h1000_0003;
        do_reset();

        // ROM address wrap at depth
        run = 1'b1;
        tick(190);
        chk("wrap_addr63", 32'(rom_addr), 32'd63);
        chk("wrap_pc252",  pc,            32'd252);
        tick(3);
        chk("wrap_addr0", 32'(rom_addr),  32'h0);
        chk("wrap_pc256", pc,             32'h100);
        chk("wrap_rd",    32'(rom_rd_en), 32'h1);
        tick(2);
        chk("wrap_ir", ir, 32'h1000_0000);
        run = 1'b0;
        tick(2);

        // 32-bit PC wrap via branch
        branch_valid = 1'b1; branch_target = 32'hFFFF_FFFF;
        step = 1'b1; tick(1); step = 1'b0;
        tick(3);
        chk("pc_top", pc, 32'hFFFF_FFFC);
        branch_valid = 1'b0;
        step = 1'b1; tick(1); step = 1'b0;
        chk("pc_top_addr", 32'(rom_addr), 32'd63);
        tick(3);
        chk("pc_wrap0", pc, 32'h0);

        // Fetch counter wrap from a preloaded 16'hFFFF
        #1 force dut.fetch_cnt_q = 16'hFFFF; preload = 1'b1;
        @(negedge clk);
        #1 release dut.fetch_cnt_q; preload = 1'b0;
        step = 1'b1; tick(1); step = 1'b0;
        tick(3);
        chk("cnt_wrap", 32'(fetch_cnt), 32'h0);
        chk("cnt_pc",   pc,             32'h4);

        // Asynchronous reset in the middle of WAIT
        run = 1'b1;
        tick(2);
        #2 rst = 1'b0;
        #1 chk_reset_vals("arst");
        @(negedge clk);
        #1 rst = 1'b1;
        tick(1);
        chk("rs_rd",   32'(rom_rd_en), 32'h1);
        chk("rs_addr", 32'(rom_addr),  32'h0);
        chk("rs_pc",   pc,             32'h0);
        tick(2);
        chk("rs_ir",    ir,            32'h1000_0000);
        chk("rs_valid", 32'(ir_valid), 32'h1);
        run = 1'b0;
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
